// File: rtl/vx_raster_stamp_csr.sv
// Raster stamp consumer: on a warp fetch request, pops one stamp per active
// lane, unpacks it into that lane's CSR set, and completes the request.
// Cores read the lane CSRs through a 1-cycle registered read port.

package vx_raster_stamp_pkg;
  // One lane's CSR set as seen by the core.
  typedef struct packed {
    logic [31:0]       pos_mask;
    logic [31:0]       pid;
    logic [11:0][31:0] bcoords;   // [4*i+j] holds bcoords[i][j]
  } raster_csrs_t;
endpackage

// Per-lane CSR storage with a combinational address decode for the read mux.
module vx_raster_stamp_lane
  import vx_raster_stamp_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en_i,
  input  raster_csrs_t wr_data_i,
  input  logic [3:0]   rd_addr_i,
  output logic [31:0]  rd_data_o
);

  raster_csrs_t csr_q;

  // CSR set register: cleared on reset, overwritten whole on a lane write.
  always_ff @(posedge clk) begin
    if (reset)        csr_q <= '0;
    else if (wr_en_i) csr_q <= wr_data_i;
  end

  // Address decode: 0 pos_mask, 1 pid, 2..13 bcoords, 14/15 read as zero.
  always_comb begin
    rd_data_o = '0;
    if (rd_addr_i == 4'd0)       rd_data_o = csr_q.pos_mask;
    else if (rd_addr_i == 4'd1)  rd_data_o = csr_q.pid;
    else if (rd_addr_i <= 4'd13) rd_data_o = csr_q.bcoords[rd_addr_i - 4'd2];
  end

endmodule

module vx_raster_stamp_csr
  import vx_raster_stamp_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  parameter  int DIM_BITS  = 12,
  parameter  int PID_BITS  = 16,
  parameter  int TAG_BITS  = 8,
  localparam int STAMP_W   = 2*(DIM_BITS-1) + 4 + 384 + PID_BITS,
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stamp_valid,
  input  logic [STAMP_W-1:0]   stamp_data,
  input  logic                 stamp_eos,
  output logic                 stamp_ready,
  input  logic                 req_valid,
  input  logic [NUM_LANES-1:0] req_tmask,
  input  logic [TAG_BITS-1:0]  req_tag,
  output logic                 req_ready,
  output logic                 rsp_valid,
  output logic [TAG_BITS-1:0]  rsp_tag,
  output logic                 rsp_empty,
  input  logic                 rsp_ready,
  input  logic                 csr_rd_valid,
  input  logic [LANE_W-1:0]    csr_rd_lane,
  input  logic [3:0]           csr_rd_addr,
  output logic [31:0]          csr_rd_data,
  output logic                 csr_rd_ack
);

  // Stamp field positions, LSB first: pid, bcoords, mask, pos_y, pos_x.
  localparam int BC_LSB   = PID_BITS;
  localparam int MASK_LSB = BC_LSB + 384;
  localparam int POSY_LSB = MASK_LSB + 4;
  localparam int POSX_LSB = POSY_LSB + DIM_BITS - 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [NUM_LANES-1:0]  pend_q, pend_d;     // active lanes still waiting for a stamp
  logic [TAG_BITS-1:0]   tag_q, tag_d;
  logic                  empty_q, empty_d;
  logic [NUM_LANES-1:0]  lowbit;             // one-hot current lane pointer
  logic [NUM_LANES-1:0]  lane_we;
  logic                  wr_zero;
  raster_csrs_t          stamp_csrs, wr_data;
  logic [NUM_LANES-1:0][31:0] lane_rd;
  logic [31:0]           rd_data_q;
  logic                  rd_ack_q;

  // Unpack the incoming stamp into CSR layout.
  assign stamp_csrs.pos_mask = 32'({stamp_data[POSY_LSB +: DIM_BITS-1],
                                    stamp_data[POSX_LSB +: DIM_BITS-1],
                                    stamp_data[MASK_LSB +: 4]});
  assign stamp_csrs.pid      = 32'(stamp_data[PID_BITS-1:0]);
  assign stamp_csrs.bcoords  = stamp_data[BC_LSB +: 384];

  // End-of-stream flushes the remaining lanes with an all-zero CSR set.
  assign wr_data = wr_zero ? '0 : stamp_csrs;

  // Lowest pending lane is the next one to fill.
  assign lowbit = pend_q & (~pend_q + NUM_LANES'(1));

  // Request FSM: next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    tag_d       = tag_q;
    empty_d     = empty_q;
    lane_we     = '0;
    wr_zero     = 1'b0;
    req_ready   = 1'b0;
    stamp_ready = 1'b0;
    rsp_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          pend_d  = req_tmask;
          tag_d   = req_tag;
          empty_d = 1'b1;
          state_d = (req_tmask == '0) ? S_RESP : S_FILL;
        end
      end
      S_FILL: begin
        stamp_ready = 1'b1;
        if (stamp_valid) begin
          lane_we = lowbit;
          pend_d  = pend_q & ~lowbit;
          empty_d = 1'b0;
          if ((pend_q & ~lowbit) == '0) state_d = S_RESP;
        end else if (stamp_eos) begin
          lane_we = pend_q;
          wr_zero = 1'b1;
          pend_d  = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request FSM state and latched request context.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      tag_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tag_q   <= tag_d;
      empty_q <= empty_d;
    end
  end

  assign rsp_tag   = rsp_valid ? tag_q : '0;
  assign rsp_empty = rsp_valid & empty_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    vx_raster_stamp_lane u_lane (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (lane_we[g]),
      .wr_data_i (wr_data),
      .rd_addr_i (csr_rd_addr),
      .rd_data_o (lane_rd[g])
    );
  end

  // Registered read port: samples pre-write lane state, so a same-cycle
  // write is seen only on the following read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
    end else begin
      rd_data_q <= csr_rd_valid ? lane_rd[csr_rd_lane] : '0;
      rd_ack_q  <= csr_rd_valid;
    end
  end

  assign csr_rd_data = rd_data_q;
  assign csr_rd_ack  = rd_ack_q;

endmodule

// File: tb/tb_vx_raster_stamp_csr.sv
// Directed bench for vx_raster_stamp_csr: table-driven CSR readback plus
// hand-written sequences for EOS flush, empty requests, back-pressure,
// read-before-write and mid-request reset.
module tb_vx_raster_stamp_csr;

  localparam int NL = 4;
  localparam int SW = 2*11 + 4 + 384 + 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          stamp_valid, stamp_eos, stamp_ready;
  logic [SW-1:0] stamp_data;
  logic          req_valid, req_ready;
  logic [NL-1:0] req_tmask;
  logic [7:0]    req_tag, rsp_tag;
  logic          rsp_valid, rsp_empty, rsp_ready;
  logic          csr_rd_valid, csr_rd_ack;
  logic [1:0]    csr_rd_lane;
  logic [3:0]    csr_rd_addr;
  logic [31:0]   csr_rd_data;

  int checks = 0;
  int errors = 0;

  vx_raster_stamp_csr dut (
    .clk(clk), .reset(reset),
    .stamp_valid(stamp_valid), .stamp_data(stamp_data), .stamp_eos(stamp_eos),
    .stamp_ready(stamp_ready),
    .req_valid(req_valid), .req_tmask(req_tmask), .req_tag(req_tag), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_empty(rsp_empty), .rsp_ready(rsp_ready),
    .csr_rd_valid(csr_rd_valid), .csr_rd_lane(csr_rd_lane), .csr_rd_addr(csr_rd_addr),
    .csr_rd_data(csr_rd_data), .csr_rd_ack(csr_rd_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  typedef struct {
    int          lane;
    int          addr;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Stamp layout MSB->LSB: pos_x, pos_y, mask, bcoords, pid; bcoords[i][j]=pid*256+4i+j.
  function automatic logic [SW-1:0] mk(input logic [10:0] px, input logic [10:0] py,
                                       input logic [3:0] m, input logic [15:0] pid);
    logic [383:0] bc;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++)
        bc[(4*i+j)*32 +: 32] = 32'(pid) * 32'd256 + 32'(4*i+j);
    return {px, py, m, bc, pid};
  endfunction

  task automatic rd(input int lane, input int addr, output logic [31:0] d);
    csr_rd_valid = 1'b1;
    csr_rd_lane  = lane[1:0];
    csr_rd_addr  = addr[3:0];
    @(posedge clk); #1;
    csr_rd_valid = 1'b0;
    chk("rd_ack", 32'(csr_rd_ack), 32'd1);
    d = csr_rd_data;
  endtask

  task automatic rd_chk(input string name, input int lane, input int addr, input logic [31:0] exp);
    logic [31:0] d;
    rd(lane, addr, d);
    chk(name, d, exp);
  endtask

  task automatic do_req(input logic [3:0] m, input logic [7:0] t);
    int n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_tmask = m; req_tag = t;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send_stamp(input logic [SW-1:0] s, input int gap);
    int n = 0;
    repeat (gap) begin @(posedge clk); #1; end
    stamp_valid = 1'b1; stamp_data = s;
    while (!stamp_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("stamp_ready_wait", 32'(stamp_ready), 32'd1);
    @(posedge clk); #1;
    stamp_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input logic [7:0] t, input logic e);
    int n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, "_tag"},   32'(rsp_tag),   32'(t));
    chk({name, "_empty"}, 32'(rsp_empty), 32'(e));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  vec_t tv [12];

  initial begin
    // T2 expectations: pos_mask = mask | pos_x<<4 | pos_y<<15 = F | 3<<4 | 2<<15
    tv[0]  = '{0,  0, 32'h0001_003F};
    tv[1]  = '{0,  1, 32'h0000_0007};
    tv[2]  = '{0,  2, 32'h0000_0700};
    tv[3]  = '{1,  1, 32'h0000_0008};
    tv[4]  = '{1,  7, 32'h0000_0805};
    tv[5]  = '{2,  1, 32'h0000_0000};
    tv[6]  = '{2,  0, 32'h0000_0000};
    tv[7]  = '{3,  1, 32'h0000_0009};
    tv[8]  = '{3,  0, 32'h0001_003F};
    tv[9]  = '{3, 13, 32'h0000_090B};
    tv[10] = '{3, 14, 32'h0000_0000};
    tv[11] = '{3, 15, 32'h0000_0000};

    reset = 1'b1; stamp_valid = 1'b0; stamp_eos = 1'b0; stamp_data = '0;
    req_valid = 1'b0; req_tmask = '0; req_tag = '0; rsp_ready = 1'b0;
    csr_rd_valid = 1'b0; csr_rd_lane = '0; csr_rd_addr = '0;

    // T1: reset state and all-zero CSRs
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("t1_req_ready",   32'(req_ready),   32'd1);
    chk("t1_rsp_valid",   32'(rsp_valid),   32'd0);
    chk("t1_stamp_ready", 32'(stamp_ready), 32'd0);
    chk("t1_rd_ack",      32'(csr_rd_ack),  32'd0);
    chk("t1_rd_data",     csr_rd_data,      32'd0);
    for (int l = 0; l < NL; l++)
      for (int a = 0; a < 16; a++)
        rd_chk("t1_csr_zero", l, a, 32'd0);
    chk("t1_rd_data_idle", csr_rd_data, 32'd0);

    // T2: tmask 1011, three stamps, lane2 skipped
    do_req(4'b1011, 8'd5);
    send_stamp(mk(11'd3, 11'd2, 4'hF, 16'd7), 0);
    send_stamp(mk(11'd3, 11'd2, 4'hF, 16'd8), 0);
    send_stamp(mk(11'd3, 11'd2, 4'hF, 16'd9), 0);
    chk("t2_latency",      32'(rsp_valid),   32'd1);
    chk("t2_stamp_ready0", 32'(stamp_ready), 32'd0);
    wait_rsp("t2_rsp", 8'd5, 1'b0);
    for (int k = 0; k < 12; k++)
      rd_chk($sformatf("t2_tbl%0d", k), tv[k].lane, tv[k].addr, tv[k].exp);

    // T3a: two stamps (second with eos also high: valid wins), then eos flush
    do_req(4'b1111, 8'd6);
    send_stamp(mk(11'h7FF, 11'h401, 4'h5, 16'h11), 0);
    stamp_eos = 1'b1;
    send_stamp(mk(11'h7FF, 11'h401, 4'h5, 16'h12), 0);
    @(posedge clk); #1;
    stamp_eos = 1'b0;
    chk("t3_eos_rsp", 32'(rsp_valid), 32'd1);
    wait_rsp("t3a_rsp", 8'd6, 1'b0);
    rd_chk("t3_l0_posmask", 0, 0, 32'h0200_FFF5);
    rd_chk("t3_l0_pid",     0, 1, 32'h11);
    rd_chk("t3_l1_pid",     1, 1, 32'h12);
    rd_chk("t3_l1_bc",      1, 13, 32'h120B);
    rd_chk("t3_l2_pid",     2, 1, 32'h0);
    rd_chk("t3_l3_pid",     3, 1, 32'h0);
    rd_chk("t3_l3_bc",      3, 13, 32'h0);
    rd_chk("t3_l3_posmask", 3, 0, 32'h0);

    // T3b: eos before any stamp -> every lane zero, empty response
    stamp_eos = 1'b1;
    do_req(4'b1111, 8'd7);
    @(posedge clk); #1;
    stamp_eos = 1'b0;
    wait_rsp("t3b_rsp", 8'd7, 1'b1);
    rd_chk("t3b_l0_pid",     0, 1, 32'h0);
    rd_chk("t3b_l0_posmask", 0, 0, 32'h0);
    rd_chk("t3b_l1_pid",     1, 1, 32'h0);

    // T4: empty tmask, stamp offered but never accepted
    stamp_valid = 1'b1; stamp_data = mk(11'd1, 11'd1, 4'h1, 16'h55);
    do_req(4'b0000, 8'd9);
    chk("t4_rsp_next",   32'(rsp_valid),   32'd1);
    chk("t4_no_stamp",   32'(stamp_ready), 32'd0);
    wait_rsp("t4_rsp", 8'd9, 1'b1);
    chk("t4_no_stamp2",  32'(stamp_ready), 32'd0);
    stamp_valid = 1'b0;

    // T5: response back-pressure
    do_req(4'b0000, 8'hA5);
    for (int c = 0; c < 5; c++) begin
      chk("t5_rsp_valid",   32'(rsp_valid),   32'd1);
      chk("t5_rsp_tag",     32'(rsp_tag),     32'hA5);
      chk("t5_req_ready",   32'(req_ready),   32'd0);
      chk("t5_stamp_ready", 32'(stamp_ready), 32'd0);
      @(posedge clk); #1;
    end
    wait_rsp("t5_rsp", 8'hA5, 1'b1);
    chk("t5_rsp_drop",  32'(rsp_valid), 32'd0);
    chk("t5_req_ready", 32'(req_ready), 32'd1);

    // T6a: read-before-write on lane 0, then gapped stamp to lane 2
    do_req(4'b0101, 8'd3);
    stamp_valid = 1'b1; stamp_data = mk(11'd1, 11'd1, 4'h1, 16'h21);
    csr_rd_valid = 1'b1; csr_rd_lane = 2'd0; csr_rd_addr = 4'd1;
    chk("t6_stamp_ready", 32'(stamp_ready), 32'd1);
    @(posedge clk); #1;
    stamp_valid = 1'b0; csr_rd_valid = 1'b0;
    chk("t6_rbw_ack", 32'(csr_rd_ack), 32'd1);
    chk("t6_rbw_old", csr_rd_data,     32'h0);
    rd_chk("t6_rbw_new", 0, 1, 32'h21);
    send_stamp(mk(11'd4, 11'd5, 4'h3, 16'h22), int'($urandom_range(1, 3)));
    wait_rsp("t6a_rsp", 8'd3, 1'b0);
    rd_chk("t6_l2_bc23",  2, 13, 32'h220B);
    rd_chk("t6_l2_pid",   2, 1,  32'h22);
    rd_chk("t6_l2_posm",  2, 0,  32'h0002_8043);
    rd_chk("t6_l1_pid",   1, 1,  32'h0);

    // T6b: reset in FILL with a stamp handshake in the reset cycle
    do_req(4'b1111, 8'd4);
    send_stamp(mk(11'd1, 11'd1, 4'h1, 16'h31), int'($urandom_range(0, 2)));
    stamp_valid = 1'b1; stamp_data = mk(11'd1, 11'd1, 4'h1, 16'h32);
    reset = 1'b1;
    @(posedge clk); #1;
    stamp_valid = 1'b0; reset = 1'b0;
    chk("t6_rst_req_ready",   32'(req_ready),   32'd1);
    chk("t6_rst_rsp_valid",   32'(rsp_valid),   32'd0);
    chk("t6_rst_stamp_ready", 32'(stamp_ready), 32'd0);
    rd_chk("t6_rst_l0_pid", 0, 1, 32'h0);
    rd_chk("t6_rst_l1_pid", 1, 1, 32'h0);
    do_req(4'b0010, 8'd8);
    send_stamp(mk(11'd2, 11'd2, 4'h2, 16'h41), 0);
    wait_rsp("t6b_rsp", 8'd8, 1'b0);
    rd_chk("t6_clean_l1", 1, 1, 32'h41);
    rd_chk("t6_clean_l0", 0, 1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
